// File: rtl/sam_str_encoder_pkg.sv
// Shared definitions for the SAM str/mode transmitter: state encoding, default
// timings and the duration-to-timer-load helper.
package sam_str_encoder_pkg;

  localparam int N_W         = 4;
  localparam int KEY_W_DEF   = 8;
  localparam int MSG_MAX_DEF = 15;
  localparam int ONE_HI_DEF  = 20;
  localparam int ONE_LO_DEF  = 12;
  localparam int ZERO_HI_DEF = 10;
  localparam int ZERO_LO_DEF = 17;
  localparam int GAP_CYC_DEF = 4;
  localparam int TERM_LO_DEF = 5;
  localparam int CFG_BITS    = N_W + 2 * KEY_W_DEF;
  localparam int TMR_W       = 5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CFG_LEAD  = 4'd1,
    S_CFG_SHIFT = 4'd2,
    S_CFG_TAIL  = 4'd3,
    S_GAP       = 4'd4,
    S_BIT_HI    = 4'd5,
    S_BIT_LO    = 4'd6,
    S_TERM_HI   = 4'd7,
    S_TERM_LO   = 4'd8
  } state_t;

  // The timer is loaded with cycles-1 so that it reads zero on the last cycle.
  function automatic logic [TMR_W-1:0] dur_load(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sam_str_encoder_if.sv
// Request/serial-line bundle between a controller and the SAM str encoder.
interface sam_str_encoder_if
  import sam_str_encoder_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int MSG_MAX = MSG_MAX_DEF
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [N_W-1:0]     cfg_n;
  logic [KEY_W-1:0]   cfg_d;
  logic [KEY_W-1:0]   cfg_capsn;
  logic               msg_valid;
  logic               msg_ready;
  logic [MSG_MAX-1:0] msg_data;
  logic               str;
  logic               mode;
  logic               configured;
  logic               busy;

  modport master (
    output cfg_valid, cfg_n, cfg_d, cfg_capsn, msg_valid, msg_data,
    input  cfg_ready, msg_ready, str, mode, configured, busy
  );

  modport slave (
    input  cfg_valid, cfg_n, cfg_d, cfg_capsn, msg_valid, msg_data,
    output cfg_ready, msg_ready, str, mode, configured, busy
  );
endinterface

// File: rtl/sam_str_encoder_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sam_str_encoder_pulse_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);
endmodule

// File: rtl/sam_str_encoder.sv
// Serial str/mode transmitter for SAM: shifts out {n,d,N} under mode=1 and
// sends messages as pulse-width coded bits closed by a terminator pulse.
module sam_str_encoder
  import sam_str_encoder_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int MSG_MAX = MSG_MAX_DEF,
  parameter int ONE_HI  = ONE_HI_DEF,
  parameter int ONE_LO  = ONE_LO_DEF,
  parameter int ZERO_HI = ZERO_HI_DEF,
  parameter int ZERO_LO = ZERO_LO_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TERM_LO = TERM_LO_DEF
) (
  input logic              clk,
  input logic              reset,
  sam_str_encoder_if.slave bus
);
  localparam int SH_W  = N_W + 2 * KEY_W;
  localparam int CNT_W = $clog2(SH_W);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SH_W - 1);
  localparam logic [N_W-1:0]   ONE_N      = N_W'(1);

  // SAM decodes a 1 as high-time longer than low-time; reject timings that break that.
  if (!(ONE_HI > ONE_LO && ZERO_HI < ZERO_LO)) begin : g_bad_timing
    $error("sam_str_encoder: need ONE_HI > ONE_LO and ZERO_HI < ZERO_LO");
  end

  state_t             state_reg, state_next;
  logic [SH_W-1:0]    sh_reg, sh_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_W-1:0]     n_reg, idx_reg;
  logic [MSG_MAX-1:0] msg_reg;
  logic               configured_reg, str_reg, mode_reg;
  logic               str_next, mode_next;
  logic               timer_load, timer_done;
  logic [TMR_W-1:0]   timer_val;
  logic               idle, cfg_go, msg_go, start_bit, cur_bit, next_bit;

  assign idle          = (state_reg == S_IDLE);
  assign bus.cfg_ready = idle;
  assign bus.msg_ready = idle & configured_reg & (n_reg != '0) & ~bus.cfg_valid;
  assign bus.busy      = ~idle;
  assign bus.str       = str_reg;
  assign bus.mode      = mode_reg;
  assign bus.configured = configured_reg;

  assign cfg_go    = idle & bus.cfg_valid;
  assign msg_go    = bus.msg_valid & bus.msg_ready;
  assign start_bit = bus.msg_data[n_reg - ONE_N];
  assign cur_bit   = msg_reg[idx_reg];
  assign next_bit  = msg_reg[idx_reg - ONE_N];

  sam_str_encoder_pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_reg)
      S_IDLE: begin
        if (cfg_go) begin
          state_next = S_CFG_LEAD;
        end else if (msg_go) begin
          state_next = S_BIT_HI;
          timer_load = 1'b1;
          timer_val  = start_bit ? dur_load(ONE_HI) : dur_load(ZERO_HI);
        end
      end
      S_CFG_LEAD:  state_next = S_CFG_SHIFT;
      S_CFG_SHIFT: if (cnt_reg == '0) state_next = S_CFG_TAIL;
      S_CFG_TAIL: begin
        state_next = S_GAP;
        timer_load = 1'b1;
        timer_val  = dur_load(GAP_CYC);
      end
      S_GAP: if (timer_done) state_next = S_IDLE;
      S_BIT_HI: begin
        if (timer_done) begin
          state_next = S_BIT_LO;
          timer_load = 1'b1;
          timer_val  = cur_bit ? dur_load(ONE_LO) : dur_load(ZERO_LO);
        end
      end
      S_BIT_LO: begin
        if (timer_done) begin
          if (idx_reg == '0) begin
            state_next = S_TERM_HI;
          end else begin
            state_next = S_BIT_HI;
            timer_load = 1'b1;
            timer_val  = next_bit ? dur_load(ONE_HI) : dur_load(ZERO_HI);
          end
        end
      end
      S_TERM_HI: begin
        state_next = S_TERM_LO;
        timer_load = 1'b1;
        timer_val  = dur_load(TERM_LO);
      end
      S_TERM_LO: if (timer_done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered lines align with it.
  always_comb begin
    mode_next = (state_next == S_CFG_LEAD) || (state_next == S_CFG_SHIFT) ||
                (state_next == S_CFG_TAIL);
    if (state_next == S_CFG_SHIFT) begin
      str_next = sh_next[SH_W-1];
    end else begin
      str_next = (state_next == S_BIT_HI) || (state_next == S_TERM_HI);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_reg  <= 1'b0;
      mode_reg <= 1'b0;
    end else begin
      str_reg  <= str_next;
      mode_reg <= mode_next;
    end
  end

  always_comb begin
    sh_next = sh_reg;
    if (cfg_go) begin
      sh_next = {bus.cfg_n, bus.cfg_d, bus.cfg_capsn};
    end else if (state_reg == S_CFG_SHIFT) begin
      sh_next = {sh_reg[SH_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_reg         <= '0;
      cnt_reg        <= '0;
      n_reg          <= '0;
      idx_reg        <= '0;
      msg_reg        <= '0;
      configured_reg <= 1'b0;
    end else begin
      sh_reg <= sh_next;
      if (cfg_go) n_reg <= bus.cfg_n;
      if (msg_go) begin
        msg_reg <= bus.msg_data;
        idx_reg <= n_reg - ONE_N;
      end else if (state_reg == S_BIT_LO && timer_done && idx_reg != '0) begin
        idx_reg <= idx_reg - ONE_N;
      end
      if (state_reg == S_CFG_LEAD) begin
        cnt_reg <= SHIFT_LAST;
      end else if (state_reg == S_CFG_SHIFT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (state_reg == S_CFG_TAIL) configured_reg <= 1'b1;
    end
  end
endmodule
